banked_ram: RTL and testbench
=============================

Name: banked_ram

Overview:
- N-way address-interleaved data RAM for the F8 softcore; generalises the fixed even/odd two-bank data RAM.
- Sits below the CPU load/store unit: one independent read port and one write port per bank.
- Adds:
  - parametrised bank count and window;
  - proper base-relative addressing and range checking;
  - registered hit flags;
  - write-first bypass;
  - a post-reset zero-fill sequencer.

Parameters:
- ADDRW, 15, CPU data address width.
- ADDRBITS, 10, log2 total RAM bytes; SIZE = 2**ADDRBITS.
- BANKBITS, 1, log2 bank count; NBANKS = 2**BANKBITS; 1 <= BANKBITS < ADDRBITS.
- TOP, 'h4000, exclusive top of the RAM window; RAMBASE = TOP - SIZE. Default window is 0x3c00..0x3fff.

Ports:
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- rd_addr, in, NBANKS*ADDRW, per-bank read address; slice b belongs to bank b.
- rd_data, out, NBANKS*8, per-bank read data, registered.
- rd_hit, out, NBANKS, per-bank registered "read was valid" flag.
- wr_addr, in, NBANKS*ADDRW, per-bank write address.
- wr_data, in, NBANKS*8, per-bank write data.
- wr_en, in, NBANKS, per-bank write strobe.
- busy, out, 1, high while zero-fill runs.
- perr, out, NBANKS, registered parity error (PARITY_EN only).
- perr_sticky, out, 1, OR-accumulated parity error (PARITY_EN only).

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Address decode, per port:
  - off = addr - RAMBASE, computed ADDRW+1 bits wide.
  - in_range = (addr >= RAMBASE) && (addr < TOP).
  - bank = off[BANKBITS-1:0].
  - row = off[ADDRBITS-1:BANKBITS]; ROWS = 2**(ADDRBITS-BANKBITS).
  - Access is valid only if in_range, bank equals the port index, and the FSM is in READY.
- Writes:
  - Valid write stores on the clk rising edge.
  - Invalid write is silently dropped: no aliasing, no wrap into the window.
- Reads:
  - Latency exactly 1 cycle.
  - Valid read: rd_data = stored byte, rd_hit = 1.
  - Invalid read: rd_data = 8'hff, rd_hit = 0.
- Same cycle, same bank, same row, both valid: write-first. rd_data returns new wr_data and the store is updated.
- FSM states CLEAR and READY:
  - Reset asserted: state = CLEAR, row counter = 0, busy = 1, rd_data = 8'hff, rd_hit = 0, perr = 0, perr_sticky = 0.
  - CLEAR: each cycle writes 8'h00 (plus correct parity) to row counter in every bank. Counter increments; on the ROWS-1 write it goes to READY. Takes exactly ROWS cycles after reset release.
  - READY: busy = 0. Stays until the next reset.
  - During CLEAR, user writes are ignored and reads return miss.
- Reset asserted mid-CLEAR or mid-READY: immediate return to CLEAR with the counter at 0; the full fill restarts.
- Wrap: the counter wraps only via the state change and never re-enters CLEAR on its own.

Optional Feature:
- Macro: BANKED_RAM_PARITY_EN.
- Defined:
  - Each row stores 9 bits; the extra bit is even parity of the data byte.
  - On a valid read, perr[b] = stored parity mismatch, registered with rd_data.
  - perr_sticky sets on any perr and clears only on reset.
  - Bypassed reads never flag.
- Undefined: storage is 8 bits; perr and perr_sticky are tied to 0; ports remain present.

Decomposition:
- Package banked_ram_pkg:
  - byte_t (8-bit), state_t enum {CLEAR, READY};
  - RD_MISS = 8'hff;
  - function in_window(addr, base, top).
- Sub-module banked_ram_bank: one bank's ROWS x (8 or 9)-bit store with a 1-cycle registered read, write-first bypass, zero-fill write mux, and parity generate/check.
- Top contains only the decoders, FSM and row counter, and a generate loop over banks.

Test Plan (defaults: base 0x3c00, 2 banks, 512 rows):
- Release reset -> busy high for exactly 512 cycles. Then read 0x3c00 and 0x3dff -> rd_data 0x00, rd_hit 1.
- Write 0x3c10 = 0xa5 on bank 0, then read it -> next-cycle rd_data[0] = 0xa5, rd_hit[0] = 1. Read 0x3c11 on bank 1 -> 0x00.
- Write 0x3bfe = 0x55 and 0x4000 = 0x66, then read them -> rd_hit 0, rd_data 0xff. Location 0x3ffe and row 0 remain 0x00.
- Same cycle, bank 0, write and read 0x3c20 with data 0x3c -> rd_data[0] = 0x3c on the next cycle.
- Write 0x3c40 = 0x77, pulse reset_n low mid-CLEAR at cycle 100, then release -> busy for 512 more cycles; 0x3c40 reads 0x00.
- PARITY_EN: force the stored parity bit of row 5 in bank 0, then read 0x3c0a -> perr[0] = 1 for one cycle, perr_sticky stays 1 until reset.

Source files
------------

// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for the N-way interleaved F8 data RAM.
// Optional parity storage is enabled by defining BANKED_RAM_PARITY_EN.
package banked_ram_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam byte_t RD_MISS = 8'hff;

    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] top
    );
        return (addr >= base) && (addr < top);
    endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// One bank of the interleaved RAM: row store, 1-cycle registered read with
// write-first bypass, zero-fill write mux and optional BANKED_RAM_PARITY_EN check.
module banked_ram_bank
    import banked_ram_pkg::*;
#(
    parameter int ROWBITS = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic [ROWBITS-1:0] clr_row,
    input  logic               wr_en,
    input  logic [ROWBITS-1:0] wr_row,
    input  byte_t              wr_data,
    input  logic               rd_en,
    input  logic [ROWBITS-1:0] rd_row,
    output byte_t              rd_data,
    output logic               rd_hit,
    output logic               perr
);

`ifdef BANKED_RAM_PARITY_EN
    localparam int W = 9;

    // Stored word carries even parity in its top bit.
    function automatic logic [W-1:0] encode(input byte_t d);
        return {^d, d};
    endfunction
`else
    localparam int W = 8;

    function automatic logic [W-1:0] encode(input byte_t d);
        return d;
    endfunction
`endif

    logic [W-1:0] mem [2**ROWBITS];
    logic [W-1:0] rd_word;
    logic         bypass;

    assign rd_word = mem[rd_row];
    assign bypass  = wr_en && (wr_row == rd_row);

    // NOTE: the array has no reset branch; the zero-fill sequencer initialises
    // it, which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[clr_row] <= encode(8'h00);
        end else if (wr_en) begin
            mem[wr_row] <= encode(wr_data);
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= RD_MISS;
            rd_hit  <= 1'b0;
        end else if (rd_en) begin
            rd_data <= bypass ? wr_data : rd_word[7:0];
            rd_hit  <= 1'b1;
        end else begin
            rd_data <= RD_MISS;
            rd_hit  <= 1'b0;
        end
    end

`ifdef BANKED_RAM_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr <= 1'b0;
        end else begin
            perr <= rd_en && !bypass && (^rd_word);
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/banked_ram.sv
// N-way address-interleaved data RAM with range-checked decode and a
// post-reset zero-fill sequencer; parity via BANKED_RAM_PARITY_EN.
module banked_ram
    import banked_ram_pkg::*;
#(
    parameter  int ADDRW    = 15,
    parameter  int ADDRBITS = 10,
    parameter  int BANKBITS = 1,
    parameter  int TOP      = 'h4000,
    localparam int NBANKS   = 2**BANKBITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NBANKS*ADDRW-1:0] rd_addr,
    output logic [NBANKS*8-1:0]     rd_data,
    output logic [NBANKS-1:0]       rd_hit,
    input  logic [NBANKS*ADDRW-1:0] wr_addr,
    input  logic [NBANKS*8-1:0]     wr_data,
    input  logic [NBANKS-1:0]       wr_en,
    output logic                    busy,
    output logic [NBANKS-1:0]       perr,
    output logic                    perr_sticky
);

    localparam int             SIZE     = 2**ADDRBITS;
    localparam int             ROWBITS  = ADDRBITS - BANKBITS;
    localparam int             BASE_INT = TOP - SIZE;
    localparam logic [ADDRW:0] RAMBASE  = BASE_INT[ADDRW:0];

    state_t             state, state_next;
    logic [ROWBITS-1:0] fill_row, fill_row_next;
    logic               ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            fill_row <= '0;
        end else begin
            state    <= state_next;
            fill_row <= fill_row_next;
        end
    end

    // NOTE: defaults come first so no path through the block leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        state_next    = state;
        fill_row_next = fill_row;
        if (state == CLEAR) begin
            fill_row_next = fill_row + 1'b1;
            if (fill_row == {ROWBITS{1'b1}}) begin
                state_next = READY;
            end
        end
    end

    assign busy  = (state == CLEAR);
    assign ready = (state == READY);

    for (genvar b = 0; b < NBANKS; b++) begin : gen_bank
        logic [ADDRW:0] rd_off, wr_off;
        logic           rd_ok, wr_ok;

        // Offsets are one bit wider so addresses below the base never alias.
        assign rd_off = {1'b0, rd_addr[b*ADDRW +: ADDRW]} - RAMBASE;
        assign wr_off = {1'b0, wr_addr[b*ADDRW +: ADDRW]} - RAMBASE;

        assign rd_ok = ready
                    && in_window(32'(rd_addr[b*ADDRW +: ADDRW]), BASE_INT, TOP)
                    && (BANKBITS'(rd_off) == BANKBITS'(b));
        assign wr_ok = ready && wr_en[b]
                    && in_window(32'(wr_addr[b*ADDRW +: ADDRW]), BASE_INT, TOP)
                    && (BANKBITS'(wr_off) == BANKBITS'(b));

        banked_ram_bank #(
            .ROWBITS (ROWBITS)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (busy),
            .clr_row (fill_row),
            .wr_en   (wr_ok),
            .wr_row  (ROWBITS'(wr_off >> BANKBITS)),
            .wr_data (wr_data[b*8 +: 8]),
            .rd_en   (rd_ok),
            .rd_row  (ROWBITS'(rd_off >> BANKBITS)),
            .rd_data (rd_data[b*8 +: 8]),
            .rd_hit  (rd_hit[b]),
            .perr    (perr[b])
        );
    end

`ifdef BANKED_RAM_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_sticky <= 1'b0;
        end else if (|perr) begin
            perr_sticky <= 1'b1;
        end
    end
`else
    assign perr_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram (default 2 banks, window 0x3c00..0x3fff);
// parity scenario runs only when BANKED_RAM_PARITY_EN is defined.
module tb_banked_ram;
    import banked_ram_pkg::*;

    localparam int ADDRW = 15;
    localparam int NB    = 2;
    localparam int ROWS  = 512;
    localparam int SIZE  = 1024;
    localparam int BASE  = 'h3c00;
    localparam int TOP   = 'h4000;
`ifdef BANKED_RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic                clk     = 1'b0;
    logic                reset_n = 1'b1;
    logic [NB*ADDRW-1:0] rd_addr, wr_addr;
    logic [NB*8-1:0]     rd_data, wr_data;
    logic [NB-1:0]       rd_hit, wr_en, perr;
    logic                busy, perr_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    int corrupt_off = -1;

    always #5 clk = ~clk;

    banked_ram dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_hit      (rd_hit),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .busy        (busy),
        .perr        (perr),
        .perr_sticky (perr_sticky)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flat byte array indexed by address offset, fill
    // modelled as a countdown of cycles after reset release.
    byte_t         m_mem [SIZE];
    int            fill_left;
    byte_t         exp_data [NB];
    logic [NB-1:0] exp_hit, exp_perr;
    logic          exp_sticky;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_left <= ROWS;
            for (int i = 0; i < SIZE; i++) m_mem[i] <= 8'h00;
            for (int b = 0; b < NB; b++) exp_data[b] <= 8'hff;
            exp_hit    <= '0;
            exp_perr   <= '0;
            exp_sticky <= 1'b0;
        end else begin : model_step
            logic [NB-1:0] p;
            int ra, wa;
            bit rv, wv;
            p = '0;
            for (int b = 0; b < NB; b++) begin
                ra = int'(rd_addr[b*ADDRW +: ADDRW]);
                wa = int'(wr_addr[b*ADDRW +: ADDRW]);
                rv = (fill_left == 0) && ra >= BASE && ra < TOP && ((ra - BASE) % NB) == b;
                wv = (fill_left == 0) && wr_en[b] && wa >= BASE && wa < TOP && ((wa - BASE) % NB) == b;
                if (rv) begin
                    exp_hit[b] <= 1'b1;
                    if (wv && wa == ra) begin
                        exp_data[b] <= wr_data[b*8 +: 8];
                    end else begin
                        exp_data[b] <= m_mem[ra - BASE];
                        p[b] = PAR && ((ra - BASE) == corrupt_off);
                    end
                end else begin
                    exp_hit[b]  <= 1'b0;
                    exp_data[b] <= 8'hff;
                end
                if (wv) m_mem[wa - BASE] <= wr_data[b*8 +: 8];
            end
            exp_perr   <= p;
            exp_sticky <= exp_sticky | (|p);
            if (fill_left > 0) fill_left <= fill_left - 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy", 32'(busy), 32'(fill_left != 0));
            for (int b = 0; b < NB; b++) begin
                check("cmp_rd_data", 32'(rd_data[b*8 +: 8]), 32'(exp_data[b]));
                check("cmp_rd_hit", 32'(rd_hit[b]), 32'(exp_hit[b]));
                check("cmp_perr", 32'(perr[b]), 32'(exp_perr[b]));
            end
            check("cmp_perr_sticky", 32'(perr_sticky), 32'(exp_sticky));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_en   = '0;
    endtask

    task automatic rd(input int b, input int a);
        rd_addr[b*ADDRW +: ADDRW] = ADDRW'(a);
    endtask

    task automatic wr(input int b, input int a, input int d);
        wr_addr[b*ADDRW +: ADDRW] = ADDRW'(a);
        wr_data[b*8 +: 8]         = 8'(d);
        wr_en[b]                  = 1'b1;
    endtask

    task automatic wait_fill(output int n);
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        idle();
        #1 reset_n = 1'b0;
        repeat (3) step();
        cmp_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_hit", 32'(rd_hit), 32'd0);
        check("rst_data", 32'(rd_data), 32'hffff);
        check("rst_sticky", 32'(perr_sticky), 32'd0);

        reset_n = 1'b1;
        wait_fill(n);
        check("fill_cycles", n, 32'd512);

        rd(0, 'h3c00); rd(1, 'h3dff); step();
        check("fill_zero_data", 32'(rd_data), 32'h0000);
        check("fill_zero_hit", 32'(rd_hit), 32'b11);

        idle(); wr(0, 'h3c10, 'ha5); step();
        idle(); rd(0, 'h3c10); rd(1, 'h3c11); step();
        check("wr_rd_data", 32'(rd_data), 32'h00a5);
        check("wr_rd_hit", 32'(rd_hit), 32'b11);

        idle(); rd(1, 'h3c10); rd(0, 'h3c11); step();
        check("wrong_bank_data", 32'(rd_data), 32'hffff);
        check("wrong_bank_hit", 32'(rd_hit), 32'b00);

        idle(); wr(0, 'h3bfe, 'h55); step();
        idle(); wr(0, 'h4000, 'h66); step();
        idle(); rd(0, 'h3bfe); step();
        check("below_base_data", 32'(rd_data[7:0]), 32'hff);
        check("below_base_hit", 32'(rd_hit[0]), 32'd0);
        idle(); rd(0, 'h4000); step();
        check("at_top_data", 32'(rd_data[7:0]), 32'hff);
        check("at_top_hit", 32'(rd_hit[0]), 32'd0);
        idle(); rd(0, 'h3ffe); rd(1, 'h3fff); step();
        check("no_alias_top", 32'(rd_data), 32'h0000);
        idle(); rd(0, 'h3c00); step();
        check("no_alias_row0", 32'(rd_data[7:0]), 32'h00);
        check("no_alias_row0_hit", 32'(rd_hit[0]), 32'd1);

        idle(); wr(0, 'h3c20, 'h3c); rd(0, 'h3c20); step();
        check("bypass_data", 32'(rd_data[7:0]), 32'h3c);
        check("bypass_hit", 32'(rd_hit[0]), 32'd1);
        idle(); rd(0, 'h3c20); step();
        check("bypass_stored", 32'(rd_data[7:0]), 32'h3c);

`ifdef BANKED_RAM_PARITY_EN
        dut.gen_bank[0].u_bank.mem[5][8] = ~dut.gen_bank[0].u_bank.mem[5][8];
        corrupt_off = 10;
        idle(); rd(0, 'h3c0a); step();
        check("par_perr", 32'(perr), 32'b01);
        check("par_sticky", 32'(perr_sticky), 32'd1);
        check("par_data", 32'(rd_data[7:0]), 32'h00);
        idle(); step();
        check("par_perr_clear", 32'(perr), 32'b00);
        check("par_sticky_hold", 32'(perr_sticky), 32'd1);
`endif

        idle(); wr(0, 'h3c40, 'h77); step();
        idle(); rd(0, 'h3c40); step();
        check("pre_reset_data", 32'(rd_data[7:0]), 32'h77);
        reset_n = 1'b0;
        corrupt_off = -1;
        step();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_sticky", 32'(perr_sticky), 32'd0);
        reset_n = 1'b1;
        rd(0, 'h3c40);
        repeat (100) step();
        check("mid_clear_busy", 32'(busy), 32'd1);
        check("mid_clear_miss", 32'(rd_hit[0]), 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wait_fill(n);
        check("refill_cycles", n, 32'd512);
        idle(); rd(0, 'h3c40); step();
        check("refill_data", 32'(rd_data[7:0]), 32'h00);
        check("refill_hit", 32'(rd_hit[0]), 32'd1);

        idle();
        step();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
